// File: rtl/twos_complement_deserializer_pkg.sv
// Shared definitions for the serial two's complement deserializer:
// the default word width and the controller state encoding.
package twos_complement_deserializer_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      CONVERT = 2'd1,
      HOLD    = 2'd2
   } state_t;

endpackage

// File: rtl/twos_complement_deserializer_negate.sv
// Bit-serial negation cell: copies bits up to and including the first 1,
// then inverts every later bit, which yields -x when fed LSB first.
module serial_negate_cell (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   input  logic in,
   output logic out
);

   logic flip;

   // Remembers that the first 1 has already passed through this word.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         flip <= 1'b0;
      end else if (enable && in) begin
         flip <= 1'b1;
      end
   end

   assign out = (enable && flip) ? ~in : in;

endmodule

// File: rtl/twos_complement_deserializer.sv
// Collects an LSB-first serial two's complement word, then derives its
// magnitude bit-serially before presenting both under a valid/ready handshake.
module twos_complement_deserializer
   import twos_complement_deserializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in,
   input  logic             in_valid,
   output logic             busy,
   output logic [WIDTH-1:0] word_out,
   output logic [WIDTH-1:0] mag_out,
   output logic             sign_out,
   output logic             min_neg,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           nextState;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] shiftReg;
   logic [WIDTH-1:0] magReg;
   logic             negIn;
   logic             negOut;
   logic             negEnable;
   logic             negClear;

   // The word register is frozen outside COLLECT, so it can be read back
   // bit by bit during CONVERT and stays stable through HOLD.
   assign negIn     = shiftReg[count];
   assign negEnable = (state == CONVERT) && shiftReg[WIDTH-1];
   assign negClear  = (state == COLLECT);

   serial_negate_cell negate (
      .clk    (clk),
      .reset  (reset),
      .clear  (negClear),
      .enable (negEnable),
      .in     (negIn),
      .out    (negOut)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= COLLECT;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         COLLECT: if (in_valid && (count == LAST)) nextState = CONVERT;
         CONVERT: if (count == LAST) nextState = HOLD;
         HOLD:    if (out_ready) nextState = COLLECT;
         default: nextState = COLLECT;
      endcase
   end

   // One counter serves both phases; it wraps to zero at each phase end.
   always_ff @(posedge clk) begin
      if (reset) begin
         count    <= '0;
         shiftReg <= '0;
         magReg   <= '0;
      end else begin
         case (state)
            COLLECT: begin
               if (in_valid) begin
                  shiftReg <= {in, shiftReg[WIDTH-1:1]};
                  count    <= (count == LAST) ? '0 : count + CW'(1);
               end
            end
            CONVERT: begin
               magReg <= {negOut, magReg[WIDTH-1:1]};
               count  <= (count == LAST) ? '0 : count + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state != COLLECT);
   assign out_valid = (state == HOLD);
   assign word_out  = shiftReg;
   assign mag_out   = magReg;
   assign sign_out  = shiftReg[WIDTH-1];
   assign min_neg   = shiftReg[WIDTH-1] && (shiftReg[WIDTH-2:0] == '0);

endmodule

// File: tb/tb_twos_complement_deserializer.sv
// Scoreboard bench for the serial two's complement deserializer (WIDTH = 8).
module tb_twos_complement_deserializer;

   typedef struct {
      logic [7:0] word;
      logic [7:0] mag;
      logic       sign;
      logic       minNeg;
   } expect_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       serialIn = 1'b0;
   logic       inValid = 1'b0;
   logic       outReady = 1'b1;
   logic       busy;
   logic [7:0] wordOut;
   logic [7:0] magOut;
   logic       signOut;
   logic       minNeg;
   logic       outValid;

   expect_t    sbq[$];
   int         checks = 0;
   int         passes = 0;
   int         cyc = 0;
   int         lastBitCyc = 0;
   logic       prevValid = 1'b0;

   twos_complement_deserializer #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in        (serialIn),
      .in_valid  (inValid),
      .busy      (busy),
      .word_out  (wordOut),
      .mag_out   (magOut),
      .sign_out  (signOut),
      .min_neg   (minNeg),
      .out_valid (outValid),
      .out_ready (outReady)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
      end else begin
         passes++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   function automatic expect_t model(input logic [7:0] w);
      expect_t e;
      e.word   = w;
      e.sign   = w[7];
      e.mag    = w[7] ? 8'(~w + 8'd1) : w;
      e.minNeg = (w == 8'h80);
      return e;
   endfunction

   // Drives one word LSB first once the block is idle; optional gaps between bits.
   task automatic applyStimulus(input logic [7:0] w, input bit gaps);
      int guard;
      guard = 0;
      inValid = 1'b0;
      while (busy && guard < 200) begin
         step();
         guard++;
      end
      if (busy) checkOutput("idle_timeout", 32'(busy), 32'd0);
      for (int i = 0; i < 8; i++) begin
         if (gaps && (i % 3 == 1)) begin
            inValid = 1'b0;
            serialIn = ~w[i];
            step();
            step();
         end
         serialIn = w[i];
         inValid = 1'b1;
         if (i == 7) begin
            sbq.push_back(model(w));
            lastBitCyc = cyc + 1;
         end
         step();
      end
      inValid = 1'b0;
   endtask

   task automatic waitDrain();
      int guard;
      guard = 0;
      while (sbq.size() != 0 && guard < 100) begin
         step();
         guard++;
      end
      if (sbq.size() != 0) begin
         checkOutput("drain_timeout", 32'(sbq.size()), 32'd0);
         sbq.delete();
      end
   endtask

   // Compares every valid cycle against the head of the scoreboard, which also
   // proves the outputs stay put while the consumer stalls.
   always @(negedge clk) begin
      if (!reset) begin
         if (outValid && !prevValid && sbq.size() != 0)
            checkOutput("latency", 32'(cyc - lastBitCyc), 32'd8);
         if (outValid) begin
            if (sbq.size() == 0) begin
               checkOutput("spurious_valid", 32'(outValid), 32'd0);
            end else begin
               checkOutput("word_out", 32'(wordOut), 32'(sbq[0].word));
               checkOutput("mag_out", 32'(magOut), 32'(sbq[0].mag));
               checkOutput("sign_out", 32'(signOut), 32'(sbq[0].sign));
               checkOutput("min_neg", 32'(minNeg), 32'(sbq[0].minNeg));
               checkOutput("busy_hold", 32'(busy), 32'd1);
               if (outReady) void'(sbq.pop_front());
            end
         end
      end
      prevValid = outValid && !reset;
   end

   initial begin
      logic [7:0] w;
      reset = 1'b1;
      step();
      step();
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_valid", 32'(outValid), 32'd0);
      checkOutput("rst_word", 32'(wordOut), 32'd0);
      checkOutput("rst_mag", 32'(magOut), 32'd0);
      reset = 1'b0;
      step();

      outReady = 1'b1;
      applyStimulus(8'h05, 1'b0);
      checkOutput("busy_convert", 32'(busy), 32'd1);
      waitDrain();
      applyStimulus(8'hFB, 1'b0);
      waitDrain();
      applyStimulus(8'h80, 1'b0);
      waitDrain();
      applyStimulus(8'h00, 1'b0);
      waitDrain();
      applyStimulus(8'h7F, 1'b0);
      waitDrain();
      applyStimulus(8'hFF, 1'b0);
      waitDrain();

      // Gapped input, stalled consumer, junk bits while busy.
      outReady = 1'b0;
      applyStimulus(8'hFB, 1'b1);
      for (int g = 0; g < 50 && !outValid; g++) begin
         serialIn = 1'($urandom_range(0, 1));
         inValid = 1'b1;
         step();
      end
      checkOutput("valid_rise", 32'(outValid), 32'd1);
      for (int h = 0; h < 5; h++) begin
         serialIn = 1'($urandom_range(0, 1));
         inValid = 1'b1;
         step();
      end
      checkOutput("valid_held", 32'(outValid), 32'd1);
      inValid = 1'b0;
      outReady = 1'b1;
      step();
      checkOutput("valid_fall", 32'(outValid), 32'd0);
      waitDrain();
      applyStimulus(8'h3C, 1'b0);
      waitDrain();

      // Reset in the middle of a word discards it.
      for (int i = 0; i < 4; i++) begin
         serialIn = 1'b1;
         inValid = 1'b1;
         step();
      end
      inValid = 1'b0;
      reset = 1'b1;
      step();
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_word", 32'(wordOut), 32'd0);
      checkOutput("midrst_valid", 32'(outValid), 32'd0);
      reset = 1'b0;
      step();
      applyStimulus(8'hFE, 1'b0);
      waitDrain();

      for (int r = 0; r < 6; r++) begin
         w = 8'($urandom_range(0, 255));
         applyStimulus(w, 1'($urandom_range(0, 1)));
         waitDrain();
      end
      for (int k = 0; k < 12; k++) step();

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
